stream_row_transpose: RTL and testbench

- Row-serial 8x8 coefficient transpose on nasti_stream_channel.
- Input: one 8-coefficient row per beat, 8 beats per block. Output: one column per beat, 8 beats per block.
- Counterpart of the single-beat block transpose. It sits between row-serial producers (IDCT row pass, entropy decode) and column-serial consumers, where a whole-block beat is too wide.
- Ping-pong double buffer sustains one beat per cycle in and out.

---
 rtl/videox_stream_pkg.sv | 22 ++
 rtl/nasti_stream_channel.sv | 27 ++
 rtl/transpose_bank.sv | 38 +++
 rtl/stream_row_transpose.sv | 134 +++++++++++++
 tb/tb_stream_row_transpose.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/videox_stream_pkg.sv
// Shared types and sizes for the videox coefficient stream blocks.
package videox_stream_pkg;

  localparam int unsigned BLK_DIM       = 8;
  localparam int unsigned IDX_W         = $clog2(BLK_DIM);
  localparam int unsigned COEF_W        = 16;
  localparam int unsigned STREAM_DATA_W = 128;
  localparam int unsigned STREAM_ID_W   = 4;
  localparam int unsigned STREAM_DEST_W = 4;
  localparam int unsigned STREAM_USER_W = 4;

  typedef logic [BLK_DIM-1:0][COEF_W-1:0] coef_row_t;
  typedef coef_row_t [BLK_DIM-1:0]        coef_blk_t;

  // Per-block sideband captured from the first row of a block.
  typedef struct packed {
    logic [STREAM_ID_W-1:0]   id;
    logic [STREAM_DEST_W-1:0] dest;
    logic [STREAM_USER_W-1:0] user;
  } stream_side_t;

endpackage

// File: rtl/nasti_stream_channel.sv
// AXI-stream style channel bundle used between videox pipeline blocks.
interface nasti_stream_channel #(
  parameter int unsigned N_DATA_BITS = videox_stream_pkg::STREAM_DATA_W,
  parameter int unsigned N_ID_BITS   = videox_stream_pkg::STREAM_ID_W,
  parameter int unsigned N_DEST_BITS = videox_stream_pkg::STREAM_DEST_W,
  parameter int unsigned N_USER_BITS = videox_stream_pkg::STREAM_USER_W
);
  logic                     t_valid;
  logic                     t_ready;
  logic [N_DATA_BITS-1:0]   t_data;
  logic [N_DATA_BITS/8-1:0] t_keep;
  logic [N_DATA_BITS/8-1:0] t_strb;
  logic                     t_last;
  logic [N_ID_BITS-1:0]     t_id;
  logic [N_DEST_BITS-1:0]   t_dest;
  logic [N_USER_BITS-1:0]   t_user;

  modport master (
    output t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/transpose_bank.sv
// One 8x8 coefficient store: row-wide write port, column-wide combinational read port.
module transpose_bank
  import videox_stream_pkg::*;
#(
  parameter int unsigned COEF_WIDTH = COEF_W
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic                                 zero_fill,
  input  logic [IDX_W-1:0]                     wr_row,
  input  logic [BLK_DIM-1:0][COEF_WIDTH-1:0]   wr_data,
  input  logic [IDX_W-1:0]                     rd_col,
  output logic [BLK_DIM-1:0][COEF_WIDTH-1:0]   rd_data_c
);

  logic [BLK_DIM-1:0][BLK_DIM-1:0][COEF_WIDTH-1:0] mem;

  // Storage is intentionally not reset; zero_fill clears the rows below a short block's last row.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int r = 0; r < int'(BLK_DIM); r++) begin
        if (r == int'(wr_row)) begin
          mem[r] <= wr_data;
        end else if (zero_fill && (r > int'(wr_row))) begin
          mem[r] <= '0;
        end
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int r = 0; r < int'(BLK_DIM); r++) begin
      rd_data_c[r] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/stream_row_transpose.sv
// Row-serial to column-serial 8x8 transpose with ping-pong banks.
// Build option STREAM_TRANSPOSE_LAST_CHECK_EN enables t_last framing checks and the sticky err output.
module stream_row_transpose
  import videox_stream_pkg::*;
#(
  parameter int unsigned COEF_WIDTH = COEF_W
) (
  input  logic                      aclk,
  input  logic                      areset,
  nasti_stream_channel.slave        in_ch,
  nasti_stream_channel.master       out_ch,
  output logic                      err
);

  localparam int unsigned ROW_BITS = BLK_DIM * COEF_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_DIM - 1);

  typedef logic [BLK_DIM-1:0][COEF_WIDTH-1:0] row_t;

  logic               wr_bank;
  logic               rd_bank;
  logic [IDX_W-1:0]   wr_row;
  logic [IDX_W-1:0]   rd_col;
  logic [1:0]         full;
  stream_side_t       side_q [2];

  logic               in_ready_c;
  logic               in_hs_c;
  logic               out_hs_c;
  logic               row_end_c;
  logic               blk_end_c;
  logic               zero_fill_c;
  logic [1:0]         full_set_c;
  logic [1:0]         full_clr_c;
  row_t               in_row_c;
  row_t               col0_c;
  row_t               col1_c;
  row_t               rd_data_c;
  stream_side_t       in_side_c;
  logic               unused_c;

  assign in_ready_c = !full[wr_bank];
  assign in_row_c   = in_ch.t_data[ROW_BITS-1:0];
  assign unused_c   = ^{in_ch.t_keep, in_ch.t_strb, in_ch.t_last, in_ch.t_data};

  // Handshakes, block framing and full-flag set/clear requests.
  always_comb begin
    in_hs_c     = in_ch.t_valid && in_ready_c;
    out_hs_c    = full[rd_bank] && out_ch.t_ready;
    row_end_c   = (wr_row == LAST_IDX);
    blk_end_c   = row_end_c;
    zero_fill_c = 1'b0;
`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
    blk_end_c   = row_end_c || in_ch.t_last;
    zero_fill_c = in_ch.t_last && !row_end_c;
`endif
    full_set_c  = '0;
    full_clr_c  = '0;
    if (in_hs_c && blk_end_c) full_set_c[wr_bank] = 1'b1;
    if (out_hs_c && (rd_col == LAST_IDX)) full_clr_c[rd_bank] = 1'b1;
    in_side_c.id   = in_ch.t_id;
    in_side_c.dest = in_ch.t_dest;
    in_side_c.user = in_ch.t_user;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_bank   <= 1'b0;
      wr_row    <= '0;
      rd_bank   <= 1'b0;
      rd_col    <= '0;
      full      <= '0;
      side_q[0] <= '0;
      side_q[1] <= '0;
    end else begin
      if (in_hs_c) begin
        wr_row <= blk_end_c ? '0 : wr_row + IDX_W'(1);
        if (blk_end_c) wr_bank <= ~wr_bank;
        if (wr_row == '0) side_q[wr_bank] <= in_side_c;
      end
      if (out_hs_c) begin
        rd_col <= rd_col + IDX_W'(1);
        if (rd_col == LAST_IDX) rd_bank <= ~rd_bank;
      end
      full <= (full & ~full_clr_c) | full_set_c;
    end
  end

`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
  // Sticky framing error: t_last must coincide exactly with the eighth row.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err <= 1'b0;
    end else if (in_hs_c && (in_ch.t_last != row_end_c)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  transpose_bank #(.COEF_WIDTH(COEF_WIDTH)) u_bank0 (
    .clk       (aclk),
    .we        (in_hs_c && (wr_bank == 1'b0)),
    .zero_fill (zero_fill_c),
    .wr_row    (wr_row),
    .wr_data   (in_row_c),
    .rd_col    (rd_col),
    .rd_data_c (col0_c)
  );

  transpose_bank #(.COEF_WIDTH(COEF_WIDTH)) u_bank1 (
    .clk       (aclk),
    .we        (in_hs_c && (wr_bank == 1'b1)),
    .zero_fill (zero_fill_c),
    .wr_row    (wr_row),
    .wr_data   (in_row_c),
    .rd_col    (rd_col),
    .rd_data_c (col1_c)
  );

  assign rd_data_c = rd_bank ? col1_c : col0_c;

  assign in_ch.t_ready  = in_ready_c;
  assign out_ch.t_valid = full[rd_bank];
  assign out_ch.t_data  = STREAM_DATA_W'(rd_data_c);
  assign out_ch.t_last  = (rd_col == LAST_IDX);
  assign out_ch.t_keep  = '1;
  assign out_ch.t_strb  = '1;
  assign out_ch.t_id    = side_q[rd_bank].id;
  assign out_ch.t_dest  = side_q[rd_bank].dest;
  assign out_ch.t_user  = side_q[rd_bank].user;

endmodule

// File: tb/tb_stream_row_transpose.sv
// Bench for stream_row_transpose: directed corner sequences plus a table of randomized stream scenarios.
module tb_stream_row_transpose;
  import videox_stream_pkg::*;

  typedef struct {
    int unsigned n_blocks;
    int unsigned vpct;
    int unsigned rpct;
    int unsigned hold;
    int unsigned exp_rows_hold;
    int unsigned exp_beats;
    bit          no_bubble;
  } scen_t;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic [3:0]   id;
    logic [3:0]   dest;
    logic [3:0]   user;
  } beat_t;

  logic aclk;
  logic areset;
  logic err;
  int   errors;
  int   checks;

  nasti_stream_channel in_if ();
  nasti_stream_channel out_if ();

  stream_row_transpose #(.COEF_WIDTH(16)) dut (
    .aclk   (aclk),
    .areset (areset),
    .in_ch  (in_if),
    .out_ch (out_if),
    .err    (err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    in_if.t_valid = 1'b0;
    out_if.t_ready = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic send_row(input logic [127:0] d, input logic last, input logic [3:0] id);
    int n = 0;
    @(posedge aclk); #1;
    in_if.t_valid = 1'b1;
    in_if.t_data  = d;
    in_if.t_last  = last;
    in_if.t_id    = id;
    in_if.t_dest  = ~id;
    in_if.t_user  = id ^ 4'h3;
    @(negedge aclk);
    while (!in_if.t_ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_row_timeout: in t_ready stuck at 0");
    end
  endtask

  task automatic recv_beat(input string nm, input logic [127:0] d, input logic last, input logic [3:0] id);
    int n = 0;
    @(negedge aclk);
    while (!out_if.t_valid && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out t_valid stuck at 0", nm);
    end
    check({nm, "_data"}, out_if.t_data, d);
    check({nm, "_last"}, 128'(out_if.t_last), 128'(last));
    check({nm, "_id"}, 128'(out_if.t_id), 128'(id));
  endtask

  // Randomized stream against a queue model that transposes each completed 8-row block.
  task automatic run_scen(input scen_t s, input int idx);
    logic [127:0] rows_m [8];
    logic [3:0]   sid, sdest, suser;
    beat_t        exp_q[$];
    beat_t        b;
    beat_t        sv;
    int           rows_pres = 0;
    int           rows_acc = 0;
    int           beats = 0;
    int           cyc = 0;
    int           first_in = -1, last_in = -1, in8 = -1, first_out = -1, last_out = -1;
    int           r;
    bit           stall = 0;
    logic         cur_acc = 1'b0;
    string        tag;
    tag = $sformatf("scen%0d", idx);
    in_if.t_valid = 1'b0;
    while (beats < int'(s.exp_beats) || rows_acc < int'(s.n_blocks * 8)) begin
      @(posedge aclk); #1;
      if (!in_if.t_valid || cur_acc) begin
        if (rows_pres < int'(s.n_blocks * 8) && $urandom_range(99) < s.vpct) begin
          in_if.t_valid = 1'b1;
          in_if.t_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
          in_if.t_id    = 4'($urandom());
          in_if.t_dest  = 4'($urandom());
          in_if.t_user  = 4'($urandom());
`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
          in_if.t_last  = ((rows_pres % 8) == 7);
`else
          in_if.t_last  = 1'($urandom());
`endif
          rows_pres++;
        end else begin
          in_if.t_valid = 1'b0;
        end
      end
      out_if.t_ready = (cyc < int'(s.hold)) ? 1'b0 : ($urandom_range(99) < s.rpct);
      @(negedge aclk);
      cur_acc = in_if.t_valid && in_if.t_ready;
      if (cur_acc) begin
        r = rows_acc % 8;
        rows_m[r] = in_if.t_data;
        if (r == 0) begin
          sid = in_if.t_id; sdest = in_if.t_dest; suser = in_if.t_user;
        end
        if (first_in < 0) first_in = cyc;
        last_in = cyc;
        rows_acc++;
        if (rows_acc == 8) in8 = cyc;
        if (r == 7) begin
          for (int c = 0; c < 8; c++) begin
            b.data = '0;
            for (int rr = 0; rr < 8; rr++) b.data[rr*16 +: 16] = rows_m[rr][c*16 +: 16];
            b.last = (c == 7);
            b.id = sid; b.dest = sdest; b.user = suser;
            exp_q.push_back(b);
          end
        end
      end
      if (s.hold != 0 && cyc == int'(s.hold) - 1) begin
        check({tag, "_rows_at_hold"}, 128'(rows_acc), 128'(s.exp_rows_hold));
        check({tag, "_ready_at_hold"}, 128'(in_if.t_ready), 128'(0));
      end
      if (stall) begin
        check({tag, "_stall_stable"},
              {out_if.t_valid, out_if.t_last, out_if.t_id, out_if.t_dest, out_if.t_user, out_if.t_data[114:0]},
              {1'b1, sv.last, sv.id, sv.dest, sv.user, sv.data[114:0]});
      end
      if (out_if.t_valid && out_if.t_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_extra_beat: got data %0h with no block expected", tag, out_if.t_data);
        end else begin
          b = exp_q.pop_front();
          check({tag, "_data"}, out_if.t_data, b.data);
          check({tag, "_side"}, {out_if.t_last, out_if.t_id, out_if.t_dest, out_if.t_user},
                {b.last, b.id, b.dest, b.user});
          check({tag, "_keep_strb"}, {out_if.t_keep, out_if.t_strb}, {32{1'b1}});
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        beats++;
      end
      stall = out_if.t_valid && !out_if.t_ready;
      if (stall) begin
        sv.data = out_if.t_data; sv.last = out_if.t_last;
        sv.id = out_if.t_id; sv.dest = out_if.t_dest; sv.user = out_if.t_user;
      end
      cyc++;
      if (cyc > 3000) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: beats %0d rows %0d", tag, beats, rows_acc);
        break;
      end
    end
    @(posedge aclk); #1;
    in_if.t_valid = 1'b0;
    out_if.t_ready = 1'b0;
    check({tag, "_beat_count"}, 128'(beats), 128'(s.exp_beats));
    check({tag, "_model_drained"}, 128'(exp_q.size()), 128'(0));
    if (s.no_bubble) begin
      check({tag, "_in_span"}, 128'(last_in - first_in), 128'(s.n_blocks * 8 - 1));
      check({tag, "_out_span"}, 128'(last_out - first_out), 128'(s.exp_beats - 1));
      check({tag, "_first_latency"}, 128'(first_out - in8), 128'(1));
    end
  endtask

  scen_t        scen [6];
  logic [127:0] rows_a [8];
  logic [127:0] rows_b [8];
  logic [127:0] exp_d;

  initial begin
    scen[0] = '{n_blocks: 1, vpct: 100, rpct: 100, hold: 0,  exp_rows_hold: 0,  exp_beats: 8,  no_bubble: 1};
    scen[1] = '{n_blocks: 4, vpct: 100, rpct: 100, hold: 0,  exp_rows_hold: 0,  exp_beats: 32, no_bubble: 1};
    scen[2] = '{n_blocks: 3, vpct: 100, rpct: 100, hold: 40, exp_rows_hold: 16, exp_beats: 24, no_bubble: 0};
    scen[3] = '{n_blocks: 6, vpct: 60,  rpct: 50,  hold: 0,  exp_rows_hold: 0,  exp_beats: 48, no_bubble: 0};
    scen[4] = '{n_blocks: 5, vpct: 90,  rpct: 30,  hold: 0,  exp_rows_hold: 0,  exp_beats: 40, no_bubble: 0};
    scen[5] = '{n_blocks: 5, vpct: 30,  rpct: 90,  hold: 0,  exp_rows_hold: 0,  exp_beats: 40, no_bubble: 0};

    errors = 0;
    checks = 0;
    aclk = 1'b0;
    in_if.t_valid = 1'b0;
    in_if.t_data = '0;
    in_if.t_keep = '0;
    in_if.t_strb = '0;
    in_if.t_last = 1'b0;
    in_if.t_id = '0;
    in_if.t_dest = '0;
    in_if.t_user = '0;
    out_if.t_ready = 1'b0;

    do_reset();
    @(negedge aclk);
    check("reset_in_ready", 128'(in_if.t_ready), 128'(1));
    check("reset_out_valid", 128'(out_if.t_valid), 128'(0));
    check("reset_err", 128'(err), 128'(0));

    // Single block with element (r,c) = 16*r+c; t_id only taken from row 0.
    out_if.t_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      exp_d = '0;
      for (int c = 0; c < 8; c++) exp_d[c*16 +: 16] = 16'(16 * r + c);
      send_row(exp_d, r == 7, (r == 0) ? 4'd3 : 4'd5);
    end
    check("single_valid_before_last_hs", 128'(out_if.t_valid), 128'(0));
    @(posedge aclk); #1;
    in_if.t_valid = 1'b0;
    check("single_valid_after_last_hs", 128'(out_if.t_valid), 128'(1));
    for (int c = 0; c < 8; c++) begin
      exp_d = '0;
      for (int r = 0; r < 8; r++) exp_d[r*16 +: 16] = 16'(16 * r + c);
      recv_beat($sformatf("single_col%0d", c), exp_d, c == 7, 4'd3);
    end
    @(posedge aclk); #1;
    out_if.t_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_scen(scen[i], i);

    // Reset while block 1 is half written and block 0 half read.
    do_reset();
    out_if.t_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      send_row({$urandom(), $urandom(), $urandom(), $urandom()}, (k % 8) == 7, 4'd1);
    end
    @(posedge aclk); #1;
    in_if.t_valid = 1'b0;
    check("midop_out_valid_before_reset", 128'(out_if.t_valid), 128'(1));
    areset = 1'b1;
    #1;
    check("midop_out_valid_in_reset", 128'(out_if.t_valid), 128'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    out_if.t_ready = 1'b0;
    @(negedge aclk);
    check("midop_out_valid_after", 128'(out_if.t_valid), 128'(0));
    check("midop_in_ready_after", 128'(in_if.t_ready), 128'(1));
    run_scen(scen[0], 6);

`ifdef STREAM_TRANSPOSE_LAST_CHECK_EN
    // Short block ended by t_last on row 5, then a correctly framed block.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      rows_a[r] = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_row(rows_a[r], r == 5, (r == 0) ? 4'd7 : 4'd15);
    end
    for (int r = 0; r < 8; r++) begin
      rows_b[r] = {$urandom(), $urandom(), $urandom(), $urandom()};
      send_row(rows_b[r], r == 7, (r == 0) ? 4'd9 : 4'd15);
    end
    @(posedge aclk); #1;
    in_if.t_valid = 1'b0;
    check("short_err_set", 128'(err), 128'(1));
    out_if.t_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_d = '0;
      for (int r = 0; r < 6; r++) exp_d[r*16 +: 16] = rows_a[r][c*16 +: 16];
      recv_beat($sformatf("short_col%0d", c), exp_d, c == 7, 4'd7);
    end
    for (int c = 0; c < 8; c++) begin
      exp_d = '0;
      for (int r = 0; r < 8; r++) exp_d[r*16 +: 16] = rows_b[r][c*16 +: 16];
      recv_beat($sformatf("after_short_col%0d", c), exp_d, c == 7, 4'd9);
    end
    @(posedge aclk); #1;
    out_if.t_ready = 1'b0;
    check("short_err_sticky", 128'(err), 128'(1));
`else
    check("err_tied_low", 128'(err), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
